// File: rtl/matmul_job_ctrl.sv
// Job controller: host write channel, matmul launch with timeout,
// and result readback from memory port A.
module matmul_job_ctrl #(
  parameter logic [9:0] RESULT_ADDR    = 10'h200,
  parameter int         DRAIN_CYCLES   = 8,
  parameter int         TIMEOUT_CYCLES = 4096
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        host_start,
  output logic        host_busy,
  output logic        host_done,
  output logic        host_timeout,
  output logic [31:0] host_result,
  input  logic        host_wr_valid,
  output logic        host_wr_ready,
  input  logic [9:0]  host_wr_addr,
  input  logic [31:0] host_wr_data,
  output logic        mm_kick_start,
  input  logic        mm_ready,
  input  logic        mm_read_en_A,
  input  logic [9:0]  mm_addr_A,
  output logic        mem_read_en_A,
  output logic [9:0]  mem_addr_A,
  input  logic [31:0] mem_data_A,
  input  logic        mm_write_en_C,
  input  logic [9:0]  mm_addr_C,
  input  logic [31:0] mm_data_C,
  output logic        mem_write_en_C,
  output logic [9:0]  mem_addr_C,
  output logic [31:0] mem_data_C
);

  typedef enum logic [2:0] {
    IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE,
    DRAIN, READ, CAPTURE, DONE
  } state_t;

  localparam logic [15:0] DRAIN_LAST = 16'(DRAIN_CYCLES - 1);
  localparam logic [15:0] TO_LAST    = 16'(TIMEOUT_CYCLES - 1);

  state_t      state, state_d;
  logic [15:0] cnt, cnt_d;
  logic        timeout_d;

  always_comb begin
    state_d   = state;
    cnt_d     = '0;
    timeout_d = host_timeout;
    unique case (state)
      IDLE: begin
        if (host_start) begin
          state_d   = LAUNCH;
          timeout_d = 1'b0;
        end
      end
      LAUNCH: state_d = WAIT_BUSY;
      WAIT_BUSY: begin
        cnt_d = cnt + 16'd1;
        if (!mm_ready) begin
          state_d = WAIT_DONE;
          cnt_d   = '0;
        end else if (cnt == TO_LAST) begin
          state_d   = IDLE;
          cnt_d     = '0;
          timeout_d = 1'b1;
        end
      end
      WAIT_DONE: begin
        cnt_d = cnt + 16'd1;
        if (mm_ready) begin
          state_d = DRAIN;
          cnt_d   = '0;
        end else if (cnt == TO_LAST) begin
          state_d   = IDLE;
          cnt_d     = '0;
          timeout_d = 1'b1;
        end
      end
      DRAIN: begin
        cnt_d = cnt + 16'd1;
        if (cnt == DRAIN_LAST) begin
          state_d = READ;
          cnt_d   = '0;
        end
      end
      READ:    state_d = CAPTURE;
      CAPTURE: state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Status outputs are flops loaded from the next state
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state         <= IDLE;
      cnt           <= '0;
      host_timeout  <= 1'b0;
      host_busy     <= 1'b0;
      mm_kick_start <= 1'b0;
      host_done     <= 1'b0;
      host_result   <= '0;
    end else begin
      state         <= state_d;
      cnt           <= cnt_d;
      host_timeout  <= timeout_d;
      host_busy     <= (state_d != IDLE);
      mm_kick_start <= (state_d == LAUNCH);
      host_done     <= (state_d == DONE);
      if (state == CAPTURE)
        host_result <= mem_data_A;
    end
  end

  // Port C: host only in IDLE, and only when matmul is not writing
  assign host_wr_ready = (state == IDLE) && !mm_write_en_C;

  always_comb begin
    mem_write_en_C = mm_write_en_C;
    mem_addr_C     = mm_addr_C;
    mem_data_C     = mm_data_C;
    if (host_wr_ready) begin
      mem_write_en_C = host_wr_valid;
      mem_addr_C     = host_wr_addr;
      mem_data_C     = host_wr_data;
    end
  end

  always_comb begin
    mem_read_en_A = mm_read_en_A;
    mem_addr_A    = mm_addr_A;
    if (state == READ) begin
      mem_read_en_A = 1'b1;
      mem_addr_A    = RESULT_ADDR;
    end
  end

endmodule

// File: doc/matmul_job_ctrl.md
# matmul_job_ctrl

Job controller between a host and `matmul_top`/`mem_top`.
- Gives the host a write channel into `mem_top` port C, shared with matmul result writes.
- Launches one matmul+pool job per `host_start` and waits for completion, with a timeout.
- After the final result writes drain, reads the result word back over port A and presents it to the host with a one-cycle done pulse.

## Interface
- `RESULT_ADDR`, 10'h200, word address of the pooled result.
- `DRAIN_CYCLES`, 8, cycles waited after `mm_ready` returns high before readback; range 1..255.
- `TIMEOUT_CYCLES`, 4096, maximum cycles allowed in each of WAIT_BUSY and WAIT_DONE; range 2..65535.
- `clk` in 1: single clock, rising edge.
- `rstn` in 1: asynchronous, active-low reset.
- `host_start` in 1: request a job; sampled only in IDLE.
- `host_busy` out 1: high in every state except IDLE.
- `host_done` out 1: one-cycle pulse when `host_result` is valid.
- `host_timeout` out 1: sticky error flag; cleared by an accepted `host_start`.
- `host_result` out 32: captured word at `RESULT_ADDR`.
- `host_wr_valid` in 1, `host_wr_ready` out 1, `host_wr_addr` in 10, `host_wr_data` in 32: host write channel.
- `mm_kick_start` out 1: kick pulse to matmul.
- `mm_ready` in 1: matmul idle/ready.
- `mm_read_en_A` in 1, `mm_addr_A` in 10: matmul port-A request.
- `mem_read_en_A` out 1, `mem_addr_A` out 10, `mem_data_A` in 32: memory port A.
- `mm_write_en_C` in 1, `mm_addr_C` in 10, `mm_data_C` in 32: matmul result write.
- `mem_write_en_C` out 1, `mem_addr_C` out 10, `mem_data_C` out 32: memory port C.

## Operation
- State machine: IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE, DRAIN, READ, CAPTURE, DONE.
- IDLE: on `host_start`, clear `host_timeout`, go to LAUNCH.
- LAUNCH: `mm_kick_start`=1 for exactly this one cycle, then go to WAIT_BUSY.
- WAIT_BUSY: go to WAIT_DONE when `mm_ready`=0.
- WAIT_DONE: go to DRAIN when `mm_ready`=1.
- DRAIN: count `DRAIN_CYCLES` cycles, then go to READ.
- READ: controller drives `mem_read_en_A`=1 and `mem_addr_A`=`RESULT_ADDR` for one cycle.
- CAPTURE: latch `mem_data_A` into `host_result`. Memory read latency is fixed at 1 cycle.
- DONE: `host_done`=1 for one cycle, then go to IDLE.
- Timeout: one shared cycle counter, cleared on entry to WAIT_BUSY and on entry to WAIT_DONE. When it reaches `TIMEOUT_CYCLES` in either state:
  - set `host_timeout`;
  - go directly to IDLE;
  - skip readback; `host_done` is not pulsed and `host_result` is unchanged.
- Port C mux, IDLE:
  - host owns the port: `host_wr_ready`=1 and `mem_write_en_C`=`host_wr_valid`, with host address and data.
  - If `mm_write_en_C`=1 in the same cycle, matmul wins and `host_wr_ready`=0 that cycle.
- Port C mux, all other states: matmul signals pass through and `host_wr_ready`=0.
- Port A mux: matmul request passes through combinationally in every state except READ, where the controller owns the port and the matmul request is dropped.
- `host_start` outside IDLE is ignored and is not queued.
- A host write completes only when `host_wr_valid` && `host_wr_ready`.
- Host must hold address and data stable until accepted.

## Timing
- Reset values:
  - state IDLE, counters 0;
  - `mm_kick_start`, `host_done`, `host_timeout`, `host_busy` all 0;
  - `host_result`=0.
- Mux outputs follow the IDLE selection during reset.
- `host_busy`, `mm_kick_start` and `host_done` are registered and decoded from state.
- Kick timing: `host_start` sampled high at edge N gives `mm_kick_start` high during cycle N+1 only, and `host_busy` high from N+1.
- Minimum job length is 1 + 1 + 1 + `DRAIN_CYCLES` + 1 + 1 + 1 cycles plus matmul run time.
- `host_result` is stable from the cycle `host_done` rises until the next CAPTURE.
- If `mm_ready` drops during the LAUNCH cycle, WAIT_BUSY exits on the next edge.
- If `mm_ready` is already 0 on entry to WAIT_DONE, the controller stays in WAIT_DONE.
- Reset asserted mid-job returns everything to reset values immediately; the matmul is reset by the same `rstn`.

## Test plan
- Host loads identity into 0x000–0x003 and all-2 rows into 0x100–0x103 via the write channel, then pulses start -> exactly one `mm_kick_start`, one `host_done`, `host_result`=32'h02020202.
- Default matrices, pulse start -> `host_result` bytes [7:0]..[31:24] = 155, 191, 255, 255 (32'hFFFFBF9B); `host_busy` low the cycle after `host_done`.
- `host_start` held high for 20 cycles during a job -> exactly one kick per job; no second job starts until IDLE is re-entered.
- `host_wr_valid` asserted during WAIT_DONE -> `host_wr_ready`=0 and no host write reaches port C; write is accepted in the first IDLE cycle.
- Stub with `mm_ready` stuck high -> `host_timeout`=1 exactly `TIMEOUT_CYCLES` cycles after WAIT_BUSY entry, `host_busy`=0, no `host_done`; the next `host_start` clears `host_timeout`.
- `rstn` pulsed low during DRAIN -> all outputs at reset values within the reset cycle; a subsequent job completes with the correct result.
